// File: rtl/rs_pkg.sv
// rs_pkg: shared payload field offsets, widths and instruction-type encodings for dispatch and the RS banks
package rs_pkg;
    localparam int TAG_W        = 6;
    localparam int DATA_W       = 76;
    localparam int SRC1_TAG_LSB = 0;
    localparam int SRC1_RDY_BIT = 6;
    localparam int SRC2_TAG_LSB = 7;
    localparam int SRC2_RDY_BIT = 13;
    typedef enum logic [1:0] {
        ITYPE_BUBBLE  = 2'b00,
        ITYPE_COMPLEX = 2'b01,
        ITYPE_FP      = 2'b10,
        ITYPE_SIMPLE  = 2'b11
    } itype_e;
endpackage

// File: rtl/rs_entry_wakeup.sv
// rs_entry_wakeup: per-entry CDB tag compare, ready-bit update and issue-ready flag (RS_CDB_FORWARD_EN selects forwarded readiness)
module rs_entry_wakeup #(
    parameter int TAG_W  = rs_pkg::TAG_W,
    parameter int DATA_W = rs_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_cdb0_valid,
    input  logic [TAG_W-1:0]  i_cdb0_tag,
    input  logic              i_cdb1_valid,
    input  logic [TAG_W-1:0]  i_cdb1_tag,
    output logic [DATA_W-1:0] o_data,
    output logic              o_rdy
);
    import rs_pkg::*;
    logic w_hit1, w_hit2;
    assign w_hit1 = (i_cdb0_valid && i_cdb0_tag == i_data[SRC1_TAG_LSB +: TAG_W]) ||
                    (i_cdb1_valid && i_cdb1_tag == i_data[SRC1_TAG_LSB +: TAG_W]);
    assign w_hit2 = (i_cdb0_valid && i_cdb0_tag == i_data[SRC2_TAG_LSB +: TAG_W]) ||
                    (i_cdb1_valid && i_cdb1_tag == i_data[SRC2_TAG_LSB +: TAG_W]);
    // a source becomes ready when either bus broadcasts its tag; both buses matching is harmless
    always_comb begin
        o_data               = i_data;
        o_data[SRC1_RDY_BIT] = i_data[SRC1_RDY_BIT] || w_hit1;
        o_data[SRC2_RDY_BIT] = i_data[SRC2_RDY_BIT] || w_hit2;
    end
`ifdef RS_CDB_FORWARD_EN
    assign o_rdy = o_data[SRC1_RDY_BIT] && o_data[SRC2_RDY_BIT];
`else
    assign o_rdy = i_data[SRC1_RDY_BIT] && i_data[SRC2_RDY_BIT];
`endif
endmodule

// File: rtl/rs_collapse_queue.sv
// rs_collapse_queue: collapsing reservation-station bank, oldest-ready issue; RS_CDB_FORWARD_EN enables same-cycle CDB wakeup into select
module rs_collapse_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = rs_pkg::TAG_W,
    parameter int DATA_W = rs_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              rs_empty,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    output logic [DATA_W-1:0] issue_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    input  logic              flush,
    output logic [3:0]        occupancy
);
    import rs_pkg::*;
    logic [DATA_W-1:0] r_data    [DEPTH];
    logic [DATA_W-1:0] w_woke    [DEPTH];
    logic [DATA_W-1:0] w_up_data [DEPTH];
    logic [DATA_W-1:0] w_ndata   [DEPTH];
    logic [DEPTH-1:0]  r_valid, w_rdy, w_up_valid, w_pick, w_nvalid;
    logic [3:0]        r_occ;
    logic [DATA_W-1:0] w_in_woke, w_issue;
    logic              w_seen, w_fire, w_we, w_above, w_placed, w_sv, w_slot;
    assign rs_empty    = r_occ < 4'(DEPTH);
    assign occupancy   = r_occ;
    assign issue_valid = w_seen;
    assign issue_data  = w_issue;
    assign w_fire      = w_seen && issue_ready;
    assign w_we        = in_valid && rs_empty;
    rs_entry_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_in_wk (
        .i_data(in_data), .i_cdb0_valid(cdb0_valid), .i_cdb0_tag(cdb0_tag),
        .i_cdb1_valid(cdb1_valid), .i_cdb1_tag(cdb1_tag), .o_data(w_in_woke), .o_rdy()
    );
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_entry_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_wk (
            .i_data(r_data[g]), .i_cdb0_valid(cdb0_valid), .i_cdb0_tag(cdb0_tag),
            .i_cdb1_valid(cdb1_valid), .i_cdb1_tag(cdb1_tag), .o_data(w_woke[g]), .o_rdy(w_rdy[g])
        );
        if (g < DEPTH - 1) begin : g_up
            assign w_up_valid[g] = r_valid[g+1];
            assign w_up_data[g]  = w_woke[g+1];
        end else begin : g_top
            assign w_up_valid[g] = 1'b0;
            assign w_up_data[g]  = '0;
        end
    end
    // pick the lowest-index ready entry and present it with both ready bits forced
    always_comb begin
        w_seen  = 1'b0;
        w_issue = '0;
        w_pick  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pick[i] = r_valid[i] && w_rdy[i] && !w_seen;
            w_seen    = w_seen || w_pick[i];
            w_issue   = w_issue | ({DATA_W{w_pick[i]}} & w_woke[i]);
        end
        w_issue[SRC1_RDY_BIT] = w_seen;
        w_issue[SRC2_RDY_BIT] = w_seen;
    end
    // collapse above the issued slot, then drop the new entry into the first free slot
    always_comb begin
        w_above  = 1'b0;
        w_placed = 1'b0;
        w_sv     = 1'b0;
        w_slot   = 1'b0;
        w_nvalid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_above     = w_above || w_pick[i];
            w_sv        = (w_fire && w_above) ? w_up_valid[i] : r_valid[i];
            w_slot      = w_we && !w_sv && !w_placed;
            w_placed    = w_placed || w_slot;
            w_nvalid[i] = w_sv || w_slot;
            w_ndata[i]  = w_slot ? w_in_woke : (w_fire && w_above) ? w_up_data[i] : w_woke[i];
        end
    end
    // storage and occupancy; flush wins over write, wakeup and issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_nvalid;
            r_data  <= w_ndata;
            r_occ   <= r_occ + 4'(w_we) - 4'(w_fire);
        end
    end
endmodule
